// File: rtl/fcw_pkg.sv
// ---------------------------------------------------------------------------
// fcw_pkg
// Shared definitions for the fully-connected layer weight streamer.
//   - fcwState_t     : load-sequencer states (IDLE, LOAD, DRAIN)
//   - fcwAddrWidth   : address width derived from the maximum inputs per neuron
//   - fcwNumWidth    : neuron-number width, wide enough to hold MAX_NUM itself
//   - fcwCfgValid    : layer-geometry check applied when a load is started
// ---------------------------------------------------------------------------
package fcw_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DRAIN = 2'd2
    } fcwState_t;

    // Addresses run 0 .. maxNw-1; keep at least one bit for degenerate sizes.
    function automatic int fcwAddrWidth(input int maxNw);
        return (maxNw > 1) ? $clog2(maxNw) : 1;
    endfunction

    // Neuron numbers are 1-based, so the value maxNum itself must fit.
    function automatic int fcwNumWidth(input int maxNum);
        return $clog2(maxNum + 1);
    endfunction

    // A geometry is usable only if every neuron is a whole number of beats
    // and both dimensions fit inside the sizes the block was built for.
    function automatic logic fcwCfgValid(input int nw, input int num,
                                         input int maxNw, input int lanes,
                                         input int maxNum);
        return (nw != 0) && (nw <= maxNw) && ((nw % lanes) == 0) &&
               (num >= 1) && (num <= maxNum);
    endfunction

endpackage

// File: rtl/fcw_out_reg.sv
// ---------------------------------------------------------------------------
// fcw_out_reg
// Single-entry valid/ready output register. A loaded payload is held until
// downstream takes it; a load in the same cycle as a take replaces the old
// entry without a bubble. The owner must only load when the entry is empty
// or being taken.
// Ports:
//   i_clk, i_rst  : clock, synchronous active-high reset
//   i_load        : capture i_data this cycle
//   i_data        : payload in
//   i_rdy         : downstream accepts the held payload
//   o_valid       : payload held
//   o_data        : held payload (RESET_VAL after reset)
// ---------------------------------------------------------------------------
module fcw_out_reg #(
    parameter int         W         = 8,
    parameter logic [W-1:0] RESET_VAL = '0
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_load,
    input  logic [W-1:0] i_data,
    input  logic         i_rdy,
    output logic         o_valid,
    output logic [W-1:0] o_data
);

    logic         r_valid;
    logic [W-1:0] r_data;

    // Capture has priority over a take; a take with no new payload empties.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_valid <= 1'b0;
            r_data  <= RESET_VAL;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
        end else if (r_valid && i_rdy) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule

// File: rtl/fc_weight_streamer.sv
// ---------------------------------------------------------------------------
// fc_weight_streamer
// Streams LANES-wide weight beats into an FC MAC array weight-write port,
// tagging each beat with its 1-based neuron number and lane-0 address.
// Layer geometry is supplied per load and latched when the load starts.
// Optional build macro: FCW_CHECKSUM_EN adds o_checksum, the sum of all
// lanes of every beat accepted in the current load.
// Ports:
//   i_sclk, i_rst          : clock, synchronous active-high reset
//   i_start                : begin a load (honoured in IDLE only)
//   i_cfg_nw, i_cfg_num    : inputs per neuron, neuron count for the load
//   i_data, i_valid, o_ready : input beat handshake
//   o_w_en, i_w_rdy        : output beat handshake
//   o_weight, o_w_num, o_w_addr : registered output beat
//   o_busy                 : load in progress
//   o_done                 : one-cycle pulse after the final beat is taken
//   o_cfg_err              : one-cycle pulse on a rejected start
//   o_checksum             : (FCW_CHECKSUM_EN only) lane sum of the load
// ---------------------------------------------------------------------------
module fc_weight_streamer
    import fcw_pkg::*;
#(
    parameter int WD      = 8,
    parameter int LANES   = 4,
    parameter int MAX_NW  = 256,
    parameter int MAX_NUM = 128,
    parameter int AW      = fcwAddrWidth(MAX_NW),
    parameter int NUMW    = fcwNumWidth(MAX_NUM)
) (
    input  logic                  i_sclk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic [AW:0]           i_cfg_nw,
    input  logic [NUMW-1:0]       i_cfg_num,
    input  logic [WD*LANES-1:0]   i_data,
    input  logic                  i_valid,
    output logic                  o_ready,
    output logic                  o_w_en,
    input  logic                  i_w_rdy,
    output logic [WD*LANES-1:0]   o_weight,
    output logic [NUMW-1:0]       o_w_num,
    output logic [AW-1:0]         o_w_addr,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_cfg_err
`ifdef FCW_CHECKSUM_EN
    ,
    output logic [WD+AW+NUMW-1:0] o_checksum
`endif
);

    localparam int PW = WD*LANES + NUMW + AW;
    localparam logic [PW-1:0] PAY_RESET = {{(WD*LANES){1'b0}}, NUMW'(1), {AW{1'b0}}};

    fcwState_t       r_state;
    logic [AW:0]     r_cfgNw;
    logic [NUMW-1:0] r_cfgNum;
    logic [AW-1:0]   r_addr;
    logic [NUMW-1:0] r_num;
    logic            r_done;
    logic            r_cfgErr;

    logic            w_outValid;
    logic [PW-1:0]   w_payOut;
    logic            w_ready;
    logic            w_accept;
    logic            w_cfgOk;
    logic [AW:0]     w_addrNext;
    logic            w_rowEnd;
    logic            w_lastBeat;

    // The stage can take a new beat whenever its single entry is empty or
    // leaving this cycle, which sustains one beat per clock.
    assign w_ready    = (r_state == LOAD) && (!w_outValid || i_w_rdy);
    assign w_accept   = i_valid && w_ready;
    assign w_cfgOk    = fcwCfgValid(int'(i_cfg_nw), int'(i_cfg_num), MAX_NW, LANES, MAX_NUM);
    assign w_addrNext = {1'b0, r_addr} + (AW+1)'(LANES);
    assign w_rowEnd   = (w_addrNext == r_cfgNw);
    assign w_lastBeat = w_rowEnd && (r_num == r_cfgNum);

    // Load sequencer: latches geometry on a good start, walks address and
    // neuron counters per accepted beat, then waits for the last beat to
    // leave the output register before signalling completion.
    always_ff @(posedge i_sclk) begin
        if (i_rst) begin
            r_state  <= IDLE;
            r_cfgNw  <= '0;
            r_cfgNum <= '0;
            r_addr   <= '0;
            r_num    <= NUMW'(1);
            r_done   <= 1'b0;
            r_cfgErr <= 1'b0;
        end else begin
            r_done   <= 1'b0;
            r_cfgErr <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (i_start) begin
                        if (w_cfgOk) begin
                            r_cfgNw  <= i_cfg_nw;
                            r_cfgNum <= i_cfg_num;
                            r_addr   <= '0;
                            r_num    <= NUMW'(1);
                            r_state  <= LOAD;
                        end else begin
                            r_cfgErr <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    if (w_accept) begin
                        if (w_rowEnd) begin
                            r_addr <= '0;
                            if (w_lastBeat) begin
                                r_state <= DRAIN;
                            end else begin
                                r_num <= r_num + NUMW'(1);
                            end
                        end else begin
                            r_addr <= w_addrNext[AW-1:0];
                        end
                    end
                end
                DRAIN: begin
                    if (!w_outValid || i_w_rdy) begin
                        r_done  <= 1'b1;
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    fcw_out_reg #(
        .W         (PW),
        .RESET_VAL (PAY_RESET)
    ) u_outReg (
        .i_clk   (i_sclk),
        .i_rst   (i_rst),
        .i_load  (w_accept),
        .i_data  ({i_data, r_num, r_addr}),
        .i_rdy   (i_w_rdy),
        .o_valid (w_outValid),
        .o_data  (w_payOut)
    );

    assign o_ready   = w_ready;
    assign o_w_en    = w_outValid;
    assign o_weight  = w_payOut[PW-1 -: WD*LANES];
    assign o_w_num   = w_payOut[AW +: NUMW];
    assign o_w_addr  = w_payOut[AW-1:0];
    assign o_busy    = (r_state == LOAD);
    assign o_done    = r_done;
    assign o_cfg_err = r_cfgErr;

`ifdef FCW_CHECKSUM_EN
    localparam int CSW = WD + AW + NUMW;

    logic [CSW-1:0] r_checksum;
    logic [CSW-1:0] w_beatSum;

    // Lane sum of the beat currently being accepted.
    always_comb begin
        w_beatSum = '0;
        for (int i = 0; i < LANES; i++) begin
            w_beatSum = w_beatSum + CSW'(i_data[i*WD +: WD]);
        end
    end

    // Cleared only by a start that actually begins a load, so the total
    // stays readable after o_done until the next load.
    always_ff @(posedge i_sclk) begin
        if (i_rst) begin
            r_checksum <= '0;
        end else if ((r_state == IDLE) && i_start && w_cfgOk) begin
            r_checksum <= '0;
        end else if (w_accept) begin
            r_checksum <= r_checksum + w_beatSum;
        end
    end

    assign o_checksum = r_checksum;
`endif

endmodule

// File: tb/tb_fc_weight_streamer.sv
// ---------------------------------------------------------------------------
// tb_fc_weight_streamer
// Directed bench for fc_weight_streamer (define FCW_CHECKSUM_EN to also
// exercise the checksum port). Inputs change on the falling edge; outputs
// are sampled 1 ns later, well away from the rising edge.
// ---------------------------------------------------------------------------
module tb_fc_weight_streamer;

    localparam int WD      = 8;
    localparam int LANES   = 4;
    localparam int MAX_NW  = 256;
    localparam int MAX_NUM = 128;
    localparam int AW      = 8;
    localparam int NUMW    = 8;
    localparam int BUDGET  = 2000;

    logic                  i_sclk = 1'b0;
    logic                  i_rst;
    logic                  i_start;
    logic [AW:0]           i_cfg_nw;
    logic [NUMW-1:0]       i_cfg_num;
    logic [WD*LANES-1:0]   i_data;
    logic                  i_valid;
    logic                  o_ready;
    logic                  o_w_en;
    logic                  i_w_rdy;
    logic [WD*LANES-1:0]   o_weight;
    logic [NUMW-1:0]       o_w_num;
    logic [AW-1:0]         o_w_addr;
    logic                  o_busy;
    logic                  o_done;
    logic                  o_cfg_err;
`ifdef FCW_CHECKSUM_EN
    logic [WD+AW+NUMW-1:0] o_checksum;
`endif

    int testsRun    = 0;
    int testsFailed = 0;

    // Observations recorded by streamLoad for the test tasks to judge.
    logic [NUMW-1:0]     obsNum  [256];
    logic [AW-1:0]       obsAddr [256];
    logic [WD*LANES-1:0] obsData [256];
    int takeCount;
    int doneCount;
    int doneCycle;
    int lastAcceptCycle;
    int stallChanges;
    int timedOut;
    logic busyAfterStart;

    fc_weight_streamer #(
        .WD(WD), .LANES(LANES), .MAX_NW(MAX_NW), .MAX_NUM(MAX_NUM), .AW(AW), .NUMW(NUMW)
    ) dut (
        .i_sclk    (i_sclk),
        .i_rst     (i_rst),
        .i_start   (i_start),
        .i_cfg_nw  (i_cfg_nw),
        .i_cfg_num (i_cfg_num),
        .i_data    (i_data),
        .i_valid   (i_valid),
        .o_ready   (o_ready),
        .o_w_en    (o_w_en),
        .i_w_rdy   (i_w_rdy),
        .o_weight  (o_weight),
        .o_w_num   (o_w_num),
        .o_w_addr  (o_w_addr),
        .o_busy    (o_busy),
        .o_done    (o_done),
        .o_cfg_err (o_cfg_err)
`ifdef FCW_CHECKSUM_EN
        ,
        .o_checksum(o_checksum)
`endif
    );

    always #5 i_sclk = ~i_sclk;

    // Weight beat number k; mode 1 is the all-ones pattern.
    function automatic logic [WD*LANES-1:0] beatData(input int k, input int mode);
        logic [WD*LANES-1:0] d;
        for (int i = 0; i < LANES; i++) begin
            d[i*WD +: WD] = (mode == 1) ? 8'h01 : 8'(k + i*37 + 5);
        end
        return d;
    endfunction

    // Starts a load and streams every beat, recording each output take.
    // rdyMode 1 toggles i_w_rdy; midStartAt >= 0 pulses a conflicting start
    // (with changed cfg inputs) once that many beats have been accepted.
    task automatic streamLoad(input int nw, input int num, input int rdyMode,
                              input int midStartAt, input int dataMode);
        int total = (nw / LANES) * num;
        int sent = 0;
        int cyc = 0;
        logic prevStalled = 1'b0;
        logic [WD*LANES+NUMW+AW-1:0] prevSnap = '0;
        takeCount = 0; doneCount = 0; doneCycle = -1; lastAcceptCycle = -1;
        stallChanges = 0; timedOut = 1;
        @(negedge i_sclk);
        i_start = 1'b1; i_cfg_nw = (AW+1)'(nw); i_cfg_num = NUMW'(num);
        @(negedge i_sclk);
        i_start = 1'b0;
        #1;
        busyAfterStart = o_busy;
        while (cyc < BUDGET) begin
            if (midStartAt >= 0 && sent == midStartAt) begin
                i_start = 1'b1; i_cfg_nw = 9'd8; i_cfg_num = 8'd2;
            end else begin
                i_start = 1'b0;
            end
            i_valid = (sent < total);
            i_data  = beatData(sent, dataMode);
            i_w_rdy = (rdyMode == 0) ? 1'b1 : ((cyc % 2) == 0);
            #1;
            if (o_done) begin
                doneCount++;
                doneCycle = cyc;
            end
            if (prevStalled && ({o_weight, o_w_num, o_w_addr} != prevSnap)) stallChanges++;
            if (o_w_en && i_w_rdy) begin
                if (takeCount < 256) begin
                    obsNum[takeCount]  = o_w_num;
                    obsAddr[takeCount] = o_w_addr;
                    obsData[takeCount] = o_weight;
                end
                takeCount++;
            end
            prevStalled = o_w_en && !i_w_rdy;
            prevSnap    = {o_weight, o_w_num, o_w_addr};
            if (i_valid && o_ready) begin
                sent++;
                lastAcceptCycle = cyc;
            end
            cyc++;
            if (doneCount > 0 && cyc > doneCycle + 3) begin
                timedOut = 0;
                break;
            end
            @(negedge i_sclk);
        end
        i_valid = 1'b0; i_start = 1'b0; i_w_rdy = 1'b1;
    endtask

    task automatic test_reset();
        i_rst = 1'b1; i_start = 1'b0; i_valid = 1'b0; i_w_rdy = 1'b1;
        i_cfg_nw = '0; i_cfg_num = '0; i_data = '0;
        repeat (2) @(negedge i_sclk);
        i_rst = 1'b0;
        #1;
        testsRun++;
        if ({o_w_en, o_ready, o_busy, o_done, o_cfg_err} !== 5'b0 ||
            o_weight !== '0 || o_w_addr !== '0 || o_w_num !== 8'd1) begin
            testsFailed++;
            $display("[TB] FAIL reset_state: en/rdy/busy/done/err=%b weight=%h addr=%0d num=%0d, required 00000 0 0 1",
                     {o_w_en, o_ready, o_busy, o_done, o_cfg_err}, o_weight, o_w_addr, o_w_num);
        end
    endtask

    task automatic test_basic();
        streamLoad(84, 10, 0, -1, 0);
        testsRun++;
        if (busyAfterStart !== 1'b1 || timedOut != 0) begin
            testsFailed++;
            $display("[TB] FAIL basic_busy: busy=%b timedOut=%0d, required 1 0", busyAfterStart, timedOut);
        end
        testsRun++;
        if (takeCount != 210) begin
            testsFailed++;
            $display("[TB] FAIL basic_takes: got %0d, required 210", takeCount);
        end
        for (int k = 0; k < 210 && k < takeCount; k++) begin
            testsRun++;
            if (obsNum[k] !== NUMW'(k/21 + 1) || obsAddr[k] !== AW'((k%21)*4) || obsData[k] !== beatData(k, 0)) begin
                testsFailed++;
                $display("[TB] FAIL basic_beat%0d: num=%0d addr=%0d data=%h, required %0d %0d %h",
                         k, obsNum[k], obsAddr[k], obsData[k], k/21 + 1, (k%21)*4, beatData(k, 0));
            end
        end
        testsRun++;
        if (doneCount != 1 || doneCycle != lastAcceptCycle + 2) begin
            testsFailed++;
            $display("[TB] FAIL basic_done: count=%0d at cycle %0d, required 1 at %0d",
                     doneCount, doneCycle, lastAcceptCycle + 2);
        end
        testsRun++;
        if (o_busy !== 1'b0 || o_ready !== 1'b0 || o_w_en !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL basic_idle_after: busy=%b ready=%b en=%b, required 0 0 0", o_busy, o_ready, o_w_en);
        end
    endtask

    task automatic test_backpressure();
        streamLoad(84, 10, 1, -1, 0);
        testsRun++;
        if (takeCount != 210 || timedOut != 0) begin
            testsFailed++;
            $display("[TB] FAIL bp_takes: got %0d timedOut=%0d, required 210 0", takeCount, timedOut);
        end
        for (int k = 0; k < 210 && k < takeCount; k++) begin
            testsRun++;
            if (obsNum[k] !== NUMW'(k/21 + 1) || obsAddr[k] !== AW'((k%21)*4) || obsData[k] !== beatData(k, 0)) begin
                testsFailed++;
                $display("[TB] FAIL bp_beat%0d: num=%0d addr=%0d data=%h, required %0d %0d %h",
                         k, obsNum[k], obsAddr[k], obsData[k], k/21 + 1, (k%21)*4, beatData(k, 0));
            end
        end
        testsRun++;
        if (stallChanges != 0 || doneCount != 1) begin
            testsFailed++;
            $display("[TB] FAIL bp_hold: changes=%0d done=%0d, required 0 1", stallChanges, doneCount);
        end
    endtask

    task automatic test_cfg_err();
        int badNw [4] = '{6, 0, 84, 260};
        int badNum[4] = '{10, 10, 0, 10};
        for (int i = 0; i < 4; i++) begin
            @(negedge i_sclk);
            i_start = 1'b1; i_cfg_nw = (AW+1)'(badNw[i]); i_cfg_num = NUMW'(badNum[i]);
            i_valid = 1'b1; i_data = beatData(i, 0);
            @(negedge i_sclk);
            i_start = 1'b0;
            #1;
            testsRun++;
            if (o_cfg_err !== 1'b1 || o_busy !== 1'b0 || o_ready !== 1'b0) begin
                testsFailed++;
                $display("[TB] FAIL cfg_err%0d: err=%b busy=%b ready=%b, required 1 0 0", i, o_cfg_err, o_busy, o_ready);
            end
            @(negedge i_sclk);
            #1;
            testsRun++;
            if (o_cfg_err !== 1'b0 || o_w_en !== 1'b0 || o_busy !== 1'b0) begin
                testsFailed++;
                $display("[TB] FAIL cfg_err_pulse%0d: err=%b en=%b busy=%b, required 0 0 0", i, o_cfg_err, o_w_en, o_busy);
            end
        end
        i_valid = 1'b0;
    endtask

    task automatic test_reset_mid();
        int acc = 0;
        int cyc = 0;
        @(negedge i_sclk);
        i_start = 1'b1; i_cfg_nw = 9'd84; i_cfg_num = 8'd10;
        @(negedge i_sclk);
        i_start = 1'b0;
        while (acc < 50 && cyc < 500) begin
            @(negedge i_sclk);
            i_valid = 1'b1; i_data = beatData(acc, 0); i_w_rdy = 1'b1;
            #1;
            if (o_ready) acc++;
            cyc++;
        end
        testsRun++;
        if (acc != 50) begin
            testsFailed++;
            $display("[TB] FAIL rstmid_accepts: got %0d, required 50", acc);
        end
        @(negedge i_sclk);
        i_rst = 1'b1; i_valid = 1'b0;
        @(negedge i_sclk);
        i_rst = 1'b0;
        #1;
        testsRun++;
        if ({o_w_en, o_ready, o_busy, o_done, o_cfg_err} !== 5'b0 ||
            o_weight !== '0 || o_w_addr !== '0 || o_w_num !== 8'd1) begin
            testsFailed++;
            $display("[TB] FAIL rstmid_state: en/rdy/busy/done/err=%b weight=%h addr=%0d num=%0d, required 00000 0 0 1",
                     {o_w_en, o_ready, o_busy, o_done, o_cfg_err}, o_weight, o_w_addr, o_w_num);
        end
        streamLoad(84, 10, 0, -1, 0);
        testsRun++;
        if (takeCount != 210 || doneCount != 1) begin
            testsFailed++;
            $display("[TB] FAIL rstmid_reload: takes=%0d done=%0d, required 210 1", takeCount, doneCount);
        end
        for (int k = 0; k < 210 && k < takeCount; k++) begin
            testsRun++;
            if (obsNum[k] !== NUMW'(k/21 + 1) || obsAddr[k] !== AW'((k%21)*4) || obsData[k] !== beatData(k, 0)) begin
                testsFailed++;
                $display("[TB] FAIL rstmid_beat%0d: num=%0d addr=%0d data=%h, required %0d %0d %h",
                         k, obsNum[k], obsAddr[k], obsData[k], k/21 + 1, (k%21)*4, beatData(k, 0));
            end
        end
    endtask

    task automatic test_start_ignored();
        streamLoad(84, 10, 0, 30, 0);
        testsRun++;
        if (takeCount != 210 || doneCount != 1 || timedOut != 0) begin
            testsFailed++;
            $display("[TB] FAIL midstart_takes: takes=%0d done=%0d timedOut=%0d, required 210 1 0",
                     takeCount, doneCount, timedOut);
        end
        for (int k = 0; k < 210 && k < takeCount; k++) begin
            testsRun++;
            if (obsNum[k] !== NUMW'(k/21 + 1) || obsAddr[k] !== AW'((k%21)*4) || obsData[k] !== beatData(k, 0)) begin
                testsFailed++;
                $display("[TB] FAIL midstart_beat%0d: num=%0d addr=%0d data=%h, required %0d %0d %h",
                         k, obsNum[k], obsAddr[k], obsData[k], k/21 + 1, (k%21)*4, beatData(k, 0));
            end
        end
    endtask

    task automatic test_small_layer();
        streamLoad(8, 3, 0, -1, 0);
        testsRun++;
        if (takeCount != 6 || doneCount != 1) begin
            testsFailed++;
            $display("[TB] FAIL small_takes: takes=%0d done=%0d, required 6 1", takeCount, doneCount);
        end
        for (int k = 0; k < 6 && k < takeCount; k++) begin
            testsRun++;
            if (obsNum[k] !== NUMW'(k/2 + 1) || obsAddr[k] !== AW'((k%2)*4)) begin
                testsFailed++;
                $display("[TB] FAIL small_beat%0d: num=%0d addr=%0d, required %0d %0d",
                         k, obsNum[k], obsAddr[k], k/2 + 1, (k%2)*4);
            end
        end
    endtask

`ifdef FCW_CHECKSUM_EN
    task automatic test_checksum();
        streamLoad(84, 10, 0, -1, 1);
        testsRun++;
        if (o_checksum !== 24'd840 || doneCount != 1) begin
            testsFailed++;
            $display("[TB] FAIL checksum: got %0d done=%0d, required 840 1", o_checksum, doneCount);
        end
        streamLoad(8, 1, 0, -1, 0);
        testsRun++;
        if (o_checksum !== 24'(2*(4*5 + 0+37+74+111) + 4)) begin
            testsFailed++;
            $display("[TB] FAIL checksum_clear: got %0d, required %0d", o_checksum, 2*(4*5 + 222) + 4);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_cfg_err();
        test_reset_mid();
        test_start_ignored();
        test_small_layer();
`ifdef FCW_CHECKSUM_EN
        test_checksum();
`endif
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
